// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Two-entry valid/ready pipeline register with a skid slot. The main entry is
// always the one presented downstream; the skid entry absorbs the one extra
// transfer that can arrive while in_ready is still high and the consumer stalls.
// in_ready is decoded from the state register only, so there is no
// combinational path from out_ready to in_ready.
//
// Optional feature: define PIPE_STAGE_STATS_EN to add saturating stall/bubble
// statistics counters and their output ports.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - synchronous, active-high; highest priority
//   flush      - discard all held entries (state -> EMPTY next cycle)
//   in_valid   - upstream entry present
//   in_ready   - stage accepts an entry this cycle
//   in_ctrl    - upstream control bundle [CTRL_W]
//   in_data    - upstream lanes, lane k at [k*DATA_W +: DATA_W]
//   out_valid  - downstream entry present
//   out_ready  - downstream accepts
//   out_ctrl   - main entry control bundle, all-zero while out_valid is 0
//   out_data   - main entry lanes, holds last value while out_valid is 0
//   occupancy  - entries held (0..2)
//   stall_cnt  - (PIPE_STAGE_STATS_EN) cycles with out_valid && !out_ready
//   bubble_cnt - (PIPE_STAGE_STATS_EN) cycles with out_ready && !out_valid
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int CTRL_W = 22,
    parameter int DATA_W = 32,
    parameter int NLANES = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [NLANES*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [NLANES*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         bubble_cnt
`endif
);

    localparam int PW = NLANES * DATA_W;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CTRL_W-1:0] r_mainCtrl;
    logic [PW-1:0]     r_mainData;
    logic [CTRL_W-1:0] r_skidCtrl;
    logic [PW-1:0]     r_skidData;

    logic              w_inFire;
    logic              w_outFire;
    logic              w_loadMainIn;
    logic              w_loadMainSkid;
    logic              w_loadSkid;

    assign in_ready  = (r_state != S_FULL);
    assign out_valid = (r_state != S_EMPTY);
    assign occupancy = r_state;
    assign out_ctrl  = out_valid ? r_mainCtrl : '0;
    assign out_data  = r_mainData;

    assign w_inFire  = in_valid && in_ready;
    assign w_outFire = out_valid && out_ready;

    // Next state and load selects. Flush overrides every fire so nothing
    // presented in the flush cycle is captured.
    always_comb begin
        w_nextState    = r_state;
        w_loadMainIn   = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_inFire) begin
                    w_nextState  = S_ONE;
                    w_loadMainIn = 1'b1;
                end
            end
            S_ONE: begin
                if (w_inFire && w_outFire) begin
                    w_nextState  = S_ONE;
                    w_loadMainIn = 1'b1;
                end else if (w_inFire) begin
                    w_nextState = S_FULL;
                    w_loadSkid  = 1'b1;
                end else if (w_outFire) begin
                    w_nextState = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_outFire) begin
                    w_nextState    = S_ONE;
                    w_loadMainSkid = 1'b1;
                end
            end
            default: begin
                w_nextState = S_EMPTY;
            end
        endcase
        if (flush) begin
            w_nextState    = S_EMPTY;
            w_loadMainIn   = 1'b0;
            w_loadMainSkid = 1'b0;
            w_loadSkid     = 1'b0;
        end
    end

    // State and entry storage. Reset clears the main entry so out_data reads 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_EMPTY;
            r_mainCtrl <= '0;
            r_mainData <= '0;
            r_skidCtrl <= '0;
            r_skidData <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_loadMainIn) begin
                r_mainCtrl <= in_ctrl;
                r_mainData <= in_data;
            end else if (w_loadMainSkid) begin
                r_mainCtrl <= r_skidCtrl;
                r_mainData <= r_skidData;
            end
            if (w_loadSkid) begin
                r_skidCtrl <= in_ctrl;
                r_skidData <= in_data;
            end
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_bubbleCnt;

    // Saturating counters; only reset clears them, flush does not.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stallCnt  <= '0;
            r_bubbleCnt <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + CNT_ONE;
            end
            if (out_ready && !out_valid && (r_bubbleCnt != '1)) begin
                r_bubbleCnt <= r_bubbleCnt + CNT_ONE;
            end
        end
    end

    assign stall_cnt  = r_stallCnt;
    assign bubble_cnt = r_bubbleCnt;
`else
    // CNT_W only sizes the statistics counters; this empty check keeps the
    // parameter referenced when they are compiled out.
    if (CNT_W < 1) begin : g_cntWidthUnused
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Directed checks of pipe_stage_skid: reset state, single transfer, stall with
// skid fill, flush while full, reset while full, optional counter saturation,
// then a randomized valid/ready run against a FIFO reference model.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int CTRL_W = 22;
    localparam int DATA_W = 32;
    localparam int NLANES = 2;
    localparam int CNT_W  = 4;
    localparam int PW     = NLANES * DATA_W;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [CTRL_W-1:0] inCtrl;
    logic [PW-1:0]     inData;
    logic              outValid;
    logic              outReady;
    logic [CTRL_W-1:0] outCtrl;
    logic [PW-1:0]     outData;
    logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0]  stallCnt;
    logic [CNT_W-1:0]  bubbleCnt;
`endif

    int total;
    int bad;

    pipe_stage_skid #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W),
        .NLANES (NLANES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_ctrl   (inCtrl),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_ctrl  (outCtrl),
        .out_data  (outData),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt  (stallCnt),
        .bubble_cnt (bubbleCnt)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [CTRL_W-1:0] c,
                                 input logic [PW-1:0] d, input logic rdy,
                                 input logic fl);
        inValid  = v;
        inCtrl   = c;
        inData   = d;
        outReady = rdy;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Entries used by the directed steps.
    localparam logic [CTRL_W-1:0] CA = 22'h155555;
    localparam logic [PW-1:0]     DA = {32'hDEADBEEF, 32'h12345678};
    localparam logic [CTRL_W-1:0] CB = 22'h0000B1;
    localparam logic [PW-1:0]     DB = {32'hB0B0B0B0, 32'h0000000B};
    localparam logic [CTRL_W-1:0] CC = 22'h2CCCCC;
    localparam logic [PW-1:0]     DC = {32'hC0C0C0C0, 32'h0000000C};
    localparam logic [CTRL_W-1:0] CF = 22'h3FFFF0;
    localparam logic [PW-1:0]     DF = {32'hF1F1F1F1, 32'hF2F2F2F2};

    initial begin
        int q[$];
        int seq;
        int s;
        logic readyBefore;
        logic inFire;
        logic outFire;

        total = 0;
        bad   = 0;
        seq   = 0;

        // Reset state
        reset = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset_occupancy", 64'(occupancy), 64'd0);
        checkOutput("reset_out_valid", 64'(outValid), 64'd0);
        checkOutput("reset_in_ready", 64'(inReady), 64'd1);
        checkOutput("reset_out_ctrl", 64'(outCtrl), 64'd0);
        checkOutput("reset_out_data", 64'(outData), 64'd0);

        // Single transfer, one-cycle latency then bubble
        applyStimulus(1'b1, CA, DA, 1'b1, 1'b0);
        tick();
        checkOutput("single_out_valid", 64'(outValid), 64'd1);
        checkOutput("single_out_ctrl", 64'(outCtrl), 64'h155555);
        checkOutput("single_out_data", 64'(outData), 64'hDEADBEEF12345678);
        checkOutput("single_occupancy", 64'(occupancy), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("bubble_out_valid", 64'(outValid), 64'd0);
        checkOutput("bubble_out_ctrl", 64'(outCtrl), 64'd0);
        checkOutput("bubble_data_hold", 64'(outData), 64'hDEADBEEF12345678);
        checkOutput("bubble_occupancy", 64'(occupancy), 64'd0);

        // Stall: A and B accepted, C held upstream
        applyStimulus(1'b1, CA, DA, 1'b0, 1'b0);
        tick();
        checkOutput("stall_a_occupancy", 64'(occupancy), 64'd1);
        checkOutput("stall_a_ctrl", 64'(outCtrl), 64'(CA));
        applyStimulus(1'b1, CB, DB, 1'b0, 1'b0);
        tick();
        checkOutput("stall_full_occupancy", 64'(occupancy), 64'd2);
        checkOutput("stall_full_in_ready", 64'(inReady), 64'd0);
        checkOutput("stall_full_ctrl", 64'(outCtrl), 64'(CA));
        applyStimulus(1'b1, CC, DC, 1'b0, 1'b0);
        tick();
        checkOutput("stall_c_held_occupancy", 64'(occupancy), 64'd2);
        checkOutput("stall_c_held_ctrl", 64'(outCtrl), 64'(CA));
        checkOutput("stall_c_held_data", 64'(outData), 64'(DA));
        applyStimulus(1'b1, CC, DC, 1'b1, 1'b0);
        #1;
        checkOutput("in_ready_no_comb_path", 64'(inReady), 64'd0);
        tick();
        checkOutput("drain_b_ctrl", 64'(outCtrl), 64'(CB));
        checkOutput("drain_b_data", 64'(outData), 64'(DB));
        checkOutput("drain_b_occupancy", 64'(occupancy), 64'd1);
        tick();
        checkOutput("drain_c_ctrl", 64'(outCtrl), 64'(CC));
        checkOutput("drain_c_data", 64'(outData), 64'(DC));
        checkOutput("drain_c_occupancy", 64'(occupancy), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_empty_valid", 64'(outValid), 64'd0);

        // Flush while full, with a valid input presented in the flush cycle
        applyStimulus(1'b1, CA, DA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, CB, DB, 1'b0, 1'b0);
        tick();
        checkOutput("preflush_occupancy", 64'(occupancy), 64'd2);
        applyStimulus(1'b1, CF, DF, 1'b0, 1'b1);
        tick();
        checkOutput("flush_occupancy", 64'(occupancy), 64'd0);
        checkOutput("flush_out_valid", 64'(outValid), 64'd0);
        checkOutput("flush_out_ctrl", 64'(outCtrl), 64'd0);
        checkOutput("flush_in_ready", 64'(inReady), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_input_dropped", 64'(outValid), 64'd0);

        // Reset while full with the consumer ready
        applyStimulus(1'b1, CA, DA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, CB, DB, 1'b0, 1'b0);
        tick();
        checkOutput("prereset_occupancy", 64'(occupancy), 64'd2);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midreset_occupancy", 64'(occupancy), 64'd0);
        checkOutput("midreset_out_data", 64'(outData), 64'd0);
        checkOutput("midreset_out_valid", 64'(outValid), 64'd0);
        checkOutput("midreset_out_ctrl", 64'(outCtrl), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
        checkOutput("midreset_stall_cnt", 64'(stallCnt), 64'd0);
        checkOutput("midreset_bubble_cnt", 64'(bubbleCnt), 64'd0);
`endif
        tick();
        checkOutput("postreset_no_emit", 64'(outValid), 64'd0);
`ifdef PIPE_STAGE_STATS_EN
        checkOutput("bubble_cnt_one", 64'(bubbleCnt), 64'd1);

        // Stall counter saturation, unaffected by flush
        applyStimulus(1'b1, CA, DA, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        checkOutput("stall_cnt_saturated", 64'(stallCnt), 64'd15);
        checkOutput("bubble_cnt_unchanged", 64'(bubbleCnt), 64'd1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_cnt_after_flush", 64'(stallCnt), 64'd15);
        checkOutput("stats_flush_occupancy", 64'(occupancy), 64'd0);
`endif

        // Randomized valid/ready traffic checked against an in-order queue
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checkOutput("rand_occupancy", 64'(occupancy), 64'(q.size()));
            applyStimulus(1'($urandom_range(0, 1)), CTRL_W'(seq),
                          {DATA_W'(~seq), DATA_W'(seq)},
                          1'($urandom_range(0, 1)), 1'b0);
            #1;
            readyBefore = inReady;
            outReady = ~outReady;
            #1;
            checkOutput("rand_in_ready_indep", 64'(inReady), 64'(readyBefore));
            outReady = ~outReady;
            #1;
            inFire  = inValid && inReady;
            outFire = outValid && outReady;
            if (outFire) begin
                if (q.size() == 0) begin
                    checkOutput("rand_unexpected_out", 64'(outValid), 64'd0);
                end else begin
                    s = q.pop_front();
                    checkOutput("rand_order_ctrl", 64'(outCtrl), 64'(CTRL_W'(s)));
                    checkOutput("rand_order_data", 64'(outData),
                                64'({DATA_W'(~s), DATA_W'(s)}));
                end
            end
            if (inFire) begin
                q.push_back(seq);
                seq++;
            end
            tick();
        end

        // Drain remaining entries within a bounded number of cycles
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            if (outValid) begin
                s = q.pop_front();
                checkOutput("drain_order_ctrl", 64'(outCtrl), 64'(CTRL_W'(s)));
            end
            tick();
        end
        checkOutput("drain_queue_empty", 64'(q.size()), 64'd0);
        checkOutput("drain_occupancy", 64'(occupancy), 64'd0);

        $display("[TB] accepted %0d random entries", seq);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter CTRL_W, default 22: control-bundle width per instruction.
REQ-002 SHALL have parameter DATA_W, default 32: width of one data lane.
REQ-003 SHALL have parameter NLANES, default 2: number of data lanes carried (lane 0 = ALU result, lane 1 = store data).
REQ-004 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-005 SHALL have port clk, input, 1: clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port flush, input, 1: discard all held entries.
REQ-008 SHALL have port in_valid, input, 1: upstream entry present.
REQ-009 SHALL have port in_ready, output, 1: stage accepts an entry this cycle.
REQ-010 SHALL have port in_ctrl, input, CTRL_W: upstream control bundle.
REQ-011 SHALL have port in_data, input, NLANES*DATA_W: upstream lanes, lane k at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL have port out_valid, output, 1: downstream entry present.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts.
REQ-014 SHALL have port out_ctrl, output, CTRL_W: held control bundle.
REQ-015 SHALL have port out_data, output, NLANES*DATA_W: held lanes.
REQ-016 SHALL have port occupancy, output, 2: entries held (0..2).

Function
REQ-017 SHALL hold up to two entries (main, skid); the state is EMPTY (0), ONE (1) or FULL (2), and occupancy SHALL equal the state.
REQ-018 SHALL define an input fire as in_valid && in_ready, and an output fire as out_valid && out_ready.
REQ-019 SHALL drive in_ready = (state != FULL), decoded from registers only, with no combinational path from out_ready.
REQ-020 SHALL drive out_valid = (state != EMPTY), and present the main entry on out_ctrl/out_data.
REQ-021 SHALL force out_ctrl to all-zero while out_valid is 0 (a bubble), and out_data SHALL then hold its last value.
REQ-022 SHALL make these transitions from EMPTY: input fire -> ONE, main <= in.
REQ-023 SHALL make these transitions from ONE: input and output fire together -> ONE, main <= in; input fire only -> FULL, skid <= in; output fire only -> EMPTY.
REQ-024 SHALL make this transition from FULL: output fire -> ONE, main <= skid; otherwise hold.
REQ-025 SHALL have a latency of 1 cycle from an input fire to out_valid when the stage is empty, and SHALL preserve entry order.
REQ-026 SHALL, when flush is high, go to EMPTY next cycle regardless of fires, and no entry presented that cycle SHALL survive.

Reset
REQ-027 SHALL give reset priority over flush and all fires.
REQ-028 SHALL, on reset, drive state EMPTY, out_valid 0, in_ready 1 in the next cycle, out_ctrl 0, out_data 0 and the counters 0.
REQ-029 SHALL, on reset asserted mid-transfer, drop held entries with no partial output.

Configuration
REQ-030 SHALL, with macro PIPE_STAGE_STATS_EN defined, add outputs stall_cnt [CNT_W] (incremented each cycle out_valid && !out_ready) and bubble_cnt [CNT_W] (incremented each cycle out_ready && !out_valid).
REQ-031 SHALL saturate both counters at all-ones, clear them only on reset, and leave them unaffected by flush.
REQ-032 SHALL, without PIPE_STAGE_STATS_EN, omit both counters and their ports, and SHALL leave all other behaviour identical.

Verification
REQ-033 SHALL be verified by this scenario: after reset, hold out_ready=1 and present ctrl=0x155555, data={0xDEADBEEF,0x12345678} for 1 cycle -> next cycle out_valid=1 with the same values; the cycle after, out_valid=0 and out_ctrl=0.
REQ-034 SHALL be verified by this scenario: hold out_ready=0 and stream three entries A, B, C -> A and B accepted, occupancy=2, in_ready=0, C held upstream; raise out_ready -> A, B, C emitted in order, one per cycle.
REQ-035 SHALL be verified by this scenario: fill to FULL, then pulse flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0, and the flushed input does not appear.
REQ-036 SHALL be verified by this scenario: assert reset while FULL with out_ready=1 -> next cycle occupancy=0, out_data=0, and no entry is emitted.
REQ-037 SHALL be verified by this scenario: with PIPE_STAGE_STATS_EN and CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); apply flush -> stall_cnt stays 15.
REQ-038 SHALL be verified by this scenario: random valid/ready at 50% each for 10000 cycles -> the output sequence equals the input sequence and in_ready never depends on out_ready in the same cycle.
